uart_rx_core: RTL and testbench

//  Serial UART receiver front end: synchronises the raw rx pin, generates a 16x oversampling tick,

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_core_if.sv | 15 +
 rtl/uart_baud_gen.sv | 26 ++
 rtl/uart_rx_core.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_core.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants.
// A future uart_tx_core can import the same package.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

  // Ticks per bit period and the tick index of a bit centre.
  localparam int OVERSAMPLE = 16;
  localparam int HALF_BIT   = 7;

endpackage

// File: rtl/uart_rx_core_if.sv
// Receiver-side bundle: serial line in, received-byte handshake out.
interface uart_rx_core_if #(
  parameter int DBIT = 8
);
  logic            rx;
  logic            rx_done_tick;
  logic [DBIT-1:0] dout;
  logic            frame_err;
  logic            busy;

  // Line driver / byte consumer side
  modport master (output rx, input rx_done_tick, dout, frame_err, busy);
  // Receiver side
  modport slave  (input rx, output rx_done_tick, dout, frame_err, busy);
endinterface

// File: rtl/uart_baud_gen.sv
// Free-running oversampling tick generator: one-clk pulse every DVSR clocks.
module uart_baud_gen #(
  parameter int DVSR = 54
) (
  input  logic clk,
  input  logic rst,
  output logic o_s_tick
);
  localparam int             CW   = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DVSR - 1);

  logic [CW-1:0] r_cnt;

  // Count 0..DVSR-1 and wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_s_tick = (r_cnt == LAST);
endmodule

// File: rtl/uart_rx_core.sv
// UART receiver front end: 2-FF synchroniser, arming flag, 16x oversampled
// start/data/stop framing, registered byte output with a one-clk done pulse.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 54
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_core_if.slave bus
);
  localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;
  // Tick counter covers one data bit (16 ticks) and the longest stop period.
  localparam int S_MAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
  localparam int SW    = $clog2(S_MAX);

  localparam logic [SW-1:0] S_HALF      = SW'(HALF_BIT);
  localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  logic           r_sync1, r_sync2;
  logic [1:0]     r_fill;
  logic           r_armed;
  logic           w_rx_s;
  logic           w_s_tick;

  uart_rx_state_t r_state, w_state_next;
  logic [SW-1:0]  r_s, w_s_next;
  logic [NW-1:0]  r_n, w_n_next;
  logic [DBIT-1:0] r_b, w_b_next;
  logic [DBIT-1:0] r_dout, w_dout_next;
  logic           r_ferr, w_ferr_next;
  logic           r_done, w_done_next;

  uart_baud_gen #(.DVSR(DVSR)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .o_s_tick (w_s_tick)
  );

  assign w_rx_s = r_sync2;

  // Two-flop synchroniser; r_fill marks when the reset value has been flushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_fill  <= 2'b00;
    end else begin
      r_sync1 <= bus.rx;
      r_sync2 <= r_sync1;
      r_fill  <= {r_fill[0], 1'b1};
    end
  end

  // Arm only on a genuinely high line (not the synchroniser reset value),
  // so a reset in the middle of a frame cannot lock onto a data bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_armed <= 1'b0;
    end else if (r_fill[1] && w_rx_s) begin
      r_armed <= 1'b1;
    end else begin
      r_armed <= r_armed;
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_dout  <= '0;
      r_ferr  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_s     <= w_s_next;
      r_n     <= w_n_next;
      r_b     <= w_b_next;
      r_dout  <= w_dout_next;
      r_ferr  <= w_ferr_next;
      r_done  <= w_done_next;
    end
  end

  // Next-state and datapath: everything holds unless an s_tick advances it.
  always_comb begin
    w_state_next = r_state;
    w_s_next     = r_s;
    w_n_next     = r_n;
    w_b_next     = r_b;
    w_dout_next  = r_dout;
    w_ferr_next  = r_ferr;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_armed && !w_rx_s) begin
          w_state_next = START;
          w_s_next     = '0;
        end else begin
          w_state_next = IDLE;
        end
      end
      START: begin
        if (w_s_tick) begin
          if (r_s == S_HALF) begin
            if (!w_rx_s) begin
              w_state_next = DATA;
              w_s_next     = '0;
              w_n_next     = '0;
            end else begin
              w_state_next = IDLE;   // start bit too short: glitch
            end
          end else begin
            w_s_next = r_s + SW'(1);
          end
        end else begin
          w_state_next = START;
        end
      end
      DATA: begin
        if (w_s_tick) begin
          if (r_s == S_BIT_LAST) begin
            w_s_next = '0;
            w_b_next = {w_rx_s, r_b[DBIT-1:1]};
            if (r_n == N_LAST) begin
              w_state_next = STOP;
            end else begin
              w_n_next = r_n + NW'(1);
            end
          end else begin
            w_s_next = r_s + SW'(1);
          end
        end else begin
          w_state_next = DATA;
        end
      end
      STOP: begin
        if (w_s_tick) begin
          if (r_s == S_STOP_LAST) begin
            w_state_next = IDLE;
            w_dout_next  = r_b;
            w_ferr_next  = ~w_rx_s;
            w_done_next  = 1'b1;
          end else begin
            w_s_next = r_s + SW'(1);
          end
        end else begin
          w_state_next = STOP;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign bus.rx_done_tick = r_done;
  assign bus.dout         = r_dout;
  assign bus.frame_err    = r_ferr;
  assign bus.busy         = (r_state != IDLE);
endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core (DVSR=4 -> 64 clk per bit).
module tb_uart_rx_core;
  localparam int DBIT = 8;
  localparam int BIT  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_core_if #(.DBIT(DBIT)) bus ();

  uart_rx_core #(.DBIT(DBIT), .SB_TICK(16), .DVSR(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] dout;
    logic       ferr;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         bc;
    int         gap;
    logic [7:0] exp_dout;
    logic       exp_ferr;
  } vec_t;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad   = 0;
  logic [7:0] last_dout = 8'h00;
  logic       prev_done = 1'b0;
  vec_t       tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one frame LSB first; a low stop bit is released early so the
  // receiver's immediate re-entry into START rejects it as a glitch.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int bc);
    bus.rx = 1'b0;
    repeat (bc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      repeat (bc) @(negedge clk);
    end
    if (stop) begin
      bus.rx = 1'b1;
      repeat (bc) @(negedge clk);
    end else begin
      bus.rx = 1'b0;
      repeat (48) @(negedge clk);
      bus.rx = 1'b1;
      repeat (bc - 48) @(negedge clk);
    end
  endtask

  // Reference model: a frame yields its data byte and frame_err = !stop bit.
  task automatic send_expect(input logic [7:0] d, input logic stop, input int bc);
    exp_t e;
    e.dout = d;
    e.ferr = ~stop;
    exp_q.push_back(e);
    last_dout = d;
    send_frame(d, stop, bc);
  endtask

  task automatic drain(input int limit);
    int w = 0;
    while (exp_q.size() != 0 && w < limit) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected frames never arrived (want 0 outstanding)", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: every done pulse is one clk wide, busy is low, and it matches the model.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.rx_done_tick === 1'b1) begin
        check("pulse_width", {31'd0, prev_done}, 32'd0);
        check("busy_at_pulse", {31'd0, bus.busy}, 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: dout=%0h frame_err=%0b, expected no pulse", bus.dout, bus.frame_err);
        end else begin
          e = exp_q.pop_front();
          check("dout", {24'd0, bus.dout}, {24'd0, e.dout});
          check("frame_err", {31'd0, bus.frame_err}, {31'd0, e.ferr});
        end
      end
      prev_done = bus.rx_done_tick;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int         busy_seen;
    logic [7:0] d;
    logic       sb;
    int         bc;
    int         gap;

    tbl[0] = '{8'h55, 1'b1, 64, 100, 8'h55, 1'b0};
    tbl[1] = '{8'hA3, 1'b1, 64,   0, 8'hA3, 1'b0};
    tbl[2] = '{8'h0F, 1'b1, 64, 100, 8'h0F, 1'b0};
    tbl[3] = '{8'hC8, 1'b0, 64, 100, 8'hC8, 1'b1};
    tbl[4] = '{8'h12, 1'b1, 64, 100, 8'h12, 1'b0};
    tbl[5] = '{8'h96, 1'b1, 62, 100, 8'h96, 1'b0};
    tbl[6] = '{8'h96, 1'b1, 66, 100, 8'h96, 1'b0};
    tbl[7] = '{8'h00, 1'b1, 64, 100, 8'h00, 1'b0};
    tbl[8] = '{8'hFF, 1'b1, 64, 100, 8'hFF, 1'b0};

    bus.rx = 1'b1;
    rst    = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_done", {31'd0, bus.rx_done_tick}, 32'd0);
    check("rst_dout", {24'd0, bus.dout}, 32'd0);
    check("rst_ferr", {31'd0, bus.frame_err}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Table-driven frames (gap 0 means the next frame follows with no idle).
    for (int i = 0; i < 9; i++) begin
      exp_t e;
      e.dout = tbl[i].exp_dout;
      e.ferr = tbl[i].exp_ferr;
      exp_q.push_back(e);
      last_dout = tbl[i].exp_dout;
      send_frame(tbl[i].data, tbl[i].stop, tbl[i].bc);
      if (tbl[i].gap != 0) begin
        drain(300);
        repeat (tbl[i].gap) @(negedge clk);
        check("busy_idle", {31'd0, bus.busy}, 32'd0);
      end
    end

    // Break: line low for 10.5 bits -> 0x00 with frame_err, then an
    // immediate restart on the still-low line that reads all ones.
    begin
      exp_t e;
      e.dout = 8'h00; e.ferr = 1'b1; exp_q.push_back(e);
      e.dout = 8'hFF; e.ferr = 1'b0; exp_q.push_back(e);
      last_dout = 8'hFF;
    end
    bus.rx = 1'b0;
    repeat (672) @(negedge clk);
    bus.rx = 1'b1;
    drain(1500);
    repeat (100) @(negedge clk);

    // Short low glitch: enters START, falls back to IDLE, no frame.
    bus.rx = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_busy_start", {31'd0, bus.busy}, 32'd1);
    repeat (10) @(negedge clk);
    bus.rx = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch_busy_end", {31'd0, bus.busy}, 32'd0);
    check("glitch_dout_kept", {24'd0, bus.dout}, {24'd0, last_dout});

    // Reset during bit 3 of 0x7E, line held low afterwards.
    d = 8'h7E;
    bus.rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.rx = d[i];
      repeat (BIT) @(negedge clk);
    end
    bus.rx = d[3];
    repeat (32) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.rx = 1'b0;
    check("midrst_dout", {24'd0, bus.dout}, 32'd0);
    check("midrst_ferr", {31'd0, bus.frame_err}, 32'd0);
    busy_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_seen++;
    end
    check("midrst_busy_while_low", busy_seen, 32'd0);
    check("midrst_dout_held", {24'd0, bus.dout}, 32'd0);
    bus.rx = 1'b1;
    repeat (20) @(negedge clk);
    send_expect(8'h7E, 1'b1, BIT);
    drain(300);
    repeat (20) @(negedge clk);

    // Randomised frames against the model.
    for (int i = 0; i < 20; i++) begin
      d   = 8'($urandom_range(0, 255));
      sb  = ($urandom_range(0, 4) != 0);
      bc  = sb ? int'($urandom_range(62, 66)) : BIT;
      gap = sb ? int'($urandom_range(0, 40)) : 100;
      send_expect(d, sb, bc);
      repeat (gap) @(negedge clk);
    end
    drain(2000);
    repeat (50) @(negedge clk);
    check("final_busy", {31'd0, bus.busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
